// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters phases A/B, then turns
// each accepted phase change into a registered step pulse or an error pulse.
module quad_decoder #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic err_clr,
  output logic en,
  output logic up_down,
  output logic err,
  output logic err_flag
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [3:0] FILT_LEN_C = 4'(FILT_LEN);

  state_t     state_q, state_d;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] filt_q, filt_d;
  logic [1:0] prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic       upd_q, upd_d;
  logic       en_q, en_d;
  logic       up_down_q, up_down_d;
  logic       err_q, err_d;
  logic       err_flag_q, err_flag_d;

  logic [3:0] cnt_inc;
  logic       reached;
  logic       step_up;
  logic       step_dn;
  logic       illegal;

  assign cnt_inc = cnt_q + 4'd1;
  assign reached = (cnt_inc == FILT_LEN_C);

  // In INIT the counter measures how long the synchronized value has been
  // stable, so a quiet 00 after reset is adopted just like any other value.
  always_comb begin
    sync1_d = {a, b};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    upd_d   = 1'b0;
    case (state_q)
      INIT: begin
        if (sync1_q != sync2_q) begin
          cnt_d = 4'd0;
        end else if (reached) begin
          filt_d  = sync2_q;
          cnt_d   = 4'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        if (sync2_q == filt_q) begin
          cnt_d = 4'd0;
        end else if (reached) begin
          filt_d = sync2_q;
          prev_d = filt_q;
          cnt_d  = 4'd0;
          upd_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Classify the accepted transition {old, new} one cycle after the update.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    case ({prev_q, filt_q})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_up = 1'b1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_dn = 1'b1;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal = 1'b1;
      default: ;
    endcase
    en_d       = upd_q & (step_up | step_dn);
    err_d      = upd_q & illegal;
    up_down_d  = en_d ? step_up : up_down_q;
    err_flag_d = err_d | (err_flag_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      filt_q     <= 2'b00;
      prev_q     <= 2'b00;
      cnt_q      <= 4'd0;
      upd_q      <= 1'b0;
      en_q       <= 1'b0;
      up_down_q  <= 1'b1;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      upd_q      <= upd_d;
      en_q       <= en_d;
      up_down_q  <= up_down_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign en       = en_q;
  assign up_down  = up_down_q;
  assign err      = err_q;
  assign err_flag = err_flag_q;

  a_en_err_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(en_q && err_q));

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized and directed bench for quad_decoder, checked against a
// position-arithmetic reference model of the quadrature decoder.
module tb_quad_decoder;
  localparam int FILT_LEN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic err_clr = 1'b0;
  logic en, up_down, err, err_flag;

  int checks = 0;
  int errors = 0;

  quad_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .err_clr(err_clr),
    .en(en), .up_down(up_down), .err(err), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  // Reference model: inputs reach the filter two edges after sampling; an
  // accepted change is scored by its distance around the 00,10,11,01 cycle.
  logic [1:0] h1 = 2'b00, h2 = 2'b00, mf = 2'b00;
  int         mrun = 0;
  bit         minit = 1'b1, pstep = 1'b0, perr = 1'b0, pdir = 1'b1;
  logic       m_en = 1'b0, m_err = 1'b0, m_ud = 1'b1, m_flag = 1'b0;

  function automatic int pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  initial begin : model
    int d;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        h1 = 2'b00; h2 = 2'b00; mf = 2'b00; mrun = 0; minit = 1'b1;
        pstep = 1'b0; perr = 1'b0; pdir = 1'b1;
        m_en = 1'b0; m_err = 1'b0; m_ud = 1'b1; m_flag = 1'b0;
      end else begin
        m_en  = pstep;
        m_err = perr;
        if (pstep) m_ud = pdir;
        if (m_err) m_flag = 1'b1;
        else if (err_clr) m_flag = 1'b0;
        pstep = 1'b0;
        perr  = 1'b0;
        if (minit) begin
          if (h1 != h2) mrun = 0;
          else begin
            mrun++;
            if (mrun == FILT_LEN) begin mf = h2; mrun = 0; minit = 1'b0; end
          end
        end else if (h2 != mf) begin
          mrun++;
          if (mrun == FILT_LEN) begin
            d = (pos(h2) - pos(mf) + 4) % 4;
            if (d == 2) perr = 1'b1;
            else begin pstep = 1'b1; pdir = (d == 1); end
            mf = h2;
            mrun = 0;
          end
        end else begin
          mrun = 0;
        end
        h2 = h1;
        h1 = {a, b};
      end
    end
  end

  // Monitor: tallies pulses and cycles where the DUT disagrees with the model.
  int mis = 0, en_cnt = 0, err_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (en !== m_en || err !== m_err || up_down !== m_ud || err_flag !== m_flag || (en === 1'b1 && err === 1'b1))
        mis++;
      if (en === 1'b1) en_cnt++;
      if (err === 1'b1) err_cnt++;
    end
  end

  task automatic hold(input logic [1:0] v, input int n);
    {a, b} = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en got %b want 0", en); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_flag got %b want 0", err_flag); end
    checks++; if (up_down !== 1'b1) begin errors++; $display("[TB] FAIL reset_ud got %b want 1", up_down); end
    rst_n = 1'b1;
    hold(2'b00, 10);
  endtask

  task automatic test_init_11();
    int e0, r0;
    {a, b} = 2'b11;
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e0 = en_cnt; r0 = err_cnt;
    hold(2'b11, 12);
    checks++; if (en_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL init11_en got %0d pulses want 0", en_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("[TB] FAIL init11_err got %0d pulses want 0", err_cnt - r0); end
    e0 = en_cnt;
    hold(2'b01, 10);
    checks++; if (en_cnt - e0 !== 1 || up_down !== 1'b1) begin errors++; $display("[TB] FAIL init11_step got %0d pulses ud %b want 1 ud 1", en_cnt - e0, up_down); end
    hold(2'b00, 10);
  endtask

  task automatic test_sequence(input string name, input logic [7:0] seq, input logic want_ud);
    int e0, r0;
    logic [7:0] s;
    s = seq;
    e0 = en_cnt; r0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      hold(s[7:6], 10);
      s = s << 2;
    end
    checks++; if (en_cnt - e0 !== 4) begin errors++; $display("[TB] FAIL %s_count got %0d want 4", name, en_cnt - e0); end
    checks++; if (up_down !== want_ud) begin errors++; $display("[TB] FAIL %s_dir got %b want %b", name, up_down, want_ud); end
    checks++; if (err_cnt - r0 !== 0) begin errors++; $display("[TB] FAIL %s_err got %0d want 0", name, err_cnt - r0); end
  endtask

  task automatic test_latency();
    int first;
    first = 0;
    {a, b} = 2'b10;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (en === 1'b1 && first == 0) first = i;
    end
    checks++; if (first !== FILT_LEN + 3) begin errors++; $display("[TB] FAIL latency got %0d want %0d", first, FILT_LEN + 3); end
    hold(2'b00, 10);
  endtask

  task automatic test_glitch();
    int e0, r0;
    e0 = en_cnt; r0 = err_cnt;
    hold(2'b10, 2);
    hold(2'b00, 12);
    checks++; if (en_cnt - e0 !== 0 || err_cnt - r0 !== 0) begin errors++; $display("[TB] FAIL glitch got en %0d err %0d want 0 0", en_cnt - e0, err_cnt - r0); end
    e0 = en_cnt;
    hold(2'b10, 10);
    checks++; if (en_cnt - e0 !== 1 || up_down !== 1'b1) begin errors++; $display("[TB] FAIL glitch_filt got %0d pulses ud %b want 1 ud 1", en_cnt - e0, up_down); end
    hold(2'b00, 10);
  endtask

  task automatic test_err();
    int e0, r0;
    e0 = en_cnt; r0 = err_cnt;
    hold(2'b11, 10);
    checks++; if (err_cnt - r0 !== 1 || en_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL err_jump got err %0d en %0d want 1 0", err_cnt - r0, en_cnt - e0); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("[TB] FAIL err_flag_set got %b want 1", err_flag); end
    checks++; if (up_down !== 1'b0) begin errors++; $display("[TB] FAIL err_ud got %b want 0", up_down); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_flag !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %b want 0", err_flag); end
    hold(2'b00, 10);
    checks++; if (err_flag !== 1'b1) begin errors++; $display("[TB] FAIL err_reset got %b want 1", err_flag); end
    {a, b} = 2'b11;
    repeat (FILT_LEN + 2) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b1 || err_flag !== 1'b1) begin errors++; $display("[TB] FAIL err_set_wins got err %b flag %b want 1 1", err, err_flag); end
    hold(2'b11, 6);
  endtask

  task automatic test_reversal();
    int e0, r0;
    hold(2'b10, 10);
    e0 = en_cnt; r0 = err_cnt;
    hold(2'b11, 10);
    checks++; if (en_cnt - e0 !== 1 || up_down !== 1'b1) begin errors++; $display("[TB] FAIL rev_up got %0d ud %b want 1 ud 1", en_cnt - e0, up_down); end
    hold(2'b10, 10);
    checks++; if (en_cnt - e0 !== 2 || up_down !== 1'b0 || err_cnt - r0 !== 0) begin errors++; $display("[TB] FAIL rev_dn got %0d ud %b err %0d want 2 ud 0 err 0", en_cnt - e0, up_down, err_cnt - r0); end
  endtask

  task automatic test_reset_pending();
    int e0, r0;
    {a, b} = 2'b11;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({en, err, err_flag, up_down} !== 4'b0001) begin errors++; $display("[TB] FAIL rstpend_out got %b want 0001", {en, err, err_flag, up_down}); end
    rst_n = 1'b1;
    e0 = en_cnt; r0 = err_cnt;
    hold(2'b11, 15);
    checks++; if (en_cnt - e0 !== 0 || err_cnt - r0 !== 0) begin errors++; $display("[TB] FAIL rstpend_pulse got en %0d err %0d want 0 0", en_cnt - e0, err_cnt - r0); end
    hold(2'b01, 10);
    checks++; if (en_cnt - e0 !== 1 || up_down !== 1'b1) begin errors++; $display("[TB] FAIL rstpend_run got %0d ud %b want 1 ud 1", en_cnt - e0, up_down); end
  endtask

  task automatic test_random();
    int e0;
    e0 = en_cnt;
    for (int i = 0; i < 400; i++) begin
      err_clr = ($urandom_range(0, 7) == 0);
      hold(2'($urandom), $urandom_range(1, 9));
    end
    err_clr = 1'b0;
    hold(2'b00, 12);
    checks++; if (en_cnt - e0 < 1) begin errors++; $display("[TB] FAIL random_activity got %0d pulses want >0", en_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_init_11();
    test_sequence("up", 8'b10_11_01_00, 1'b1);
    test_latency();
    test_sequence("down", 8'b01_11_10_00, 1'b0);
    test_glitch();
    test_sequence("down2", 8'b01_11_10_00, 1'b0);
    test_err();
    test_reversal();
    test_reset_pending();
    test_random();
    checks++; if (mis !== 0) begin errors++; $display("[TB] FAIL model_trace got %0d mismatching cycles want 0", mis); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter: FILT_LEN, default 3, number of consecutive clock edges a synchronized input change must persist before acceptance; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  1  quadrature phase A, asynchronous to clk.
REQ-005 b  input  1  quadrature phase B, asynchronous to clk.
REQ-006 err_clr  input  1  synchronous clear of err_flag, active-high.
REQ-007 en  output  1  one-cycle step pulse, drives the up/down counter enable.
REQ-008 up_down  output  1  direction: 1 = up, 0 = down; valid whenever en = 1, held between steps.
REQ-009 err  output  1  one-cycle pulse on an illegal phase transition.
REQ-010 err_flag  output  1  sticky error indicator.

Function
REQ-011 a and b SHALL each pass through a 2-flop synchronizer; phase state is {a,b} after synchronization.
REQ-012 Glitch filter: a 4-bit counter SHALL count consecutive edges where the synchronized state differs from the filtered state; the count resets to 0 when they match.
REQ-013 The filtered state SHALL adopt the synchronized state on the edge at which the differing count reaches FILT_LEN, with the counter returning to 0.
REQ-014 A change that reverts before FILT_LEN edges SHALL produce no filtered update, no en, no err.
REQ-015 FSM states: INIT, RUN; reset enters INIT.
REQ-016 INIT: the first filtered update (or a synchronized state stable for FILT_LEN edges, including 00) SHALL load the filtered state, emit no en/err, and move to RUN.
REQ-017 RUN, up sequence (A leads): 00->10->11->01->00; each such transition SHALL assert en with up_down = 1.
REQ-018 RUN, down sequence: 00->01->11->10->00; each such transition SHALL assert en with up_down = 0.
REQ-019 RUN, both bits changing (00<->11, 10<->01) SHALL assert err for one cycle, set err_flag, leave en = 0 and up_down unchanged; the filtered state still updates.
REQ-020 en, up_down and err SHALL be registered; en/err high exactly one cycle, on the edge after the filtered update.
REQ-021 Latency: a clean input change first sampled at edge 0 SHALL produce en/err high after edge FILT_LEN+2 (edge 5 at default), low after edge FILT_LEN+3.
REQ-022 en and err SHALL never be high in the same cycle; at most one step per filtered update.
REQ-023 Direction reversal (e.g. 10->11 then 11->10) SHALL yield en with up_down = 1, then en with up_down = 0, no err.
REQ-024 err_flag clears on the edge where err_clr = 1, unless err is asserted on that same edge; set wins over clear.

Reset
REQ-025 While rst_n = 0: en = 0, err = 0, err_flag = 0, up_down = 1, synchronizers = 00, filtered state = 00, filter count = 0, FSM = INIT.
REQ-026 Reset assertion mid-sequence SHALL clear all state immediately and discard any pending filter count; after release, REQ-016 applies.

Verification
REQ-027 Reset release with a=b=1 held, FILT_LEN=3 -> no en, no err; FSM in RUN with filtered = 11 after edge 5.
REQ-028 From 00, drive 10,11,01,00 with each held 10 cycles -> four en pulses, up_down = 1, each en high after edge 5 from its change; counter advances by 4.
REQ-029 From 00, drive 01,11,10,00 -> four en pulses, up_down = 0; err never asserted.
REQ-030 From 00, 2-cycle pulse a = 1 -> no en, no err, filtered stays 00.
REQ-031 From 00, jump to 11 -> err one cycle, err_flag = 1, en = 0, up_down unchanged; err_clr one cycle -> err_flag = 0 after the next edge; err_clr coincident with a new err -> err_flag stays 1.
REQ-032 Assert rst_n = 0 for 1 cycle while a step is pending in the filter -> no en; all outputs at reset values.
